// File: rtl/vector_writeback_pipeline.sv
// Vector writeback pipeline: four registered stages between execute and the
// vector register file. Each stage exposes its contents as a bypass source;
// stage 4 commits to the register file when the pipeline advances.

`ifndef REG_IDX_WIDTH
`define REG_IDX_WIDTH 5
`endif
`ifndef VECTOR_LANES
`define VECTOR_LANES 16
`endif
`ifndef VECTOR_BITS
`define VECTOR_BITS (`VECTOR_LANES*32)
`endif

module vector_writeback_pipeline (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       stall_i,
   input  logic                       flush_i,
   input  logic                       result_write_i,
   input  logic [`REG_IDX_WIDTH-1:0]  result_register_i,
   input  logic [`VECTOR_BITS-1:0]    result_value_i,
   input  logic [`VECTOR_LANES-1:0]   result_mask_i,
   output logic [`REG_IDX_WIDTH-1:0]  bypass1_register_o,
   output logic                       bypass1_write_o,
   output logic [`VECTOR_BITS-1:0]    bypass1_value_o,
   output logic [`VECTOR_LANES-1:0]   bypass1_mask_o,
   output logic [`REG_IDX_WIDTH-1:0]  bypass2_register_o,
   output logic                       bypass2_write_o,
   output logic [`VECTOR_BITS-1:0]    bypass2_value_o,
   output logic [`VECTOR_LANES-1:0]   bypass2_mask_o,
   output logic [`REG_IDX_WIDTH-1:0]  bypass3_register_o,
   output logic                       bypass3_write_o,
   output logic [`VECTOR_BITS-1:0]    bypass3_value_o,
   output logic [`VECTOR_LANES-1:0]   bypass3_mask_o,
   output logic [`REG_IDX_WIDTH-1:0]  bypass4_register_o,
   output logic                       bypass4_write_o,
   output logic [`VECTOR_BITS-1:0]    bypass4_value_o,
   output logic [`VECTOR_LANES-1:0]   bypass4_mask_o,
   output logic                       rf_write_o,
   output logic [`REG_IDX_WIDTH-1:0]  rf_register_o,
   output logic [`VECTOR_BITS-1:0]    rf_value_o,
   output logic [`VECTOR_LANES-1:0]   rf_mask_o,
   output logic [2:0]                 pending_count_o
);

   // Index 0 is stage 1 (youngest), index 3 is stage 4 (commit stage).
   logic [`REG_IDX_WIDTH-1:0] reg_q  [4];
   logic [`REG_IDX_WIDTH-1:0] reg_d  [4];
   logic                      wr_q   [4];
   logic                      wr_d   [4];
   logic [`VECTOR_BITS-1:0]   val_q  [4];
   logic [`VECTOR_BITS-1:0]   val_d  [4];
   logic [`VECTOR_LANES-1:0]  mask_q [4];
   logic [`VECTOR_LANES-1:0]  mask_d [4];
   logic [2:0]                count_q;
   logic [2:0]                count_d;
   logic                      in_valid;
   logic                      enter;
   logic                      retire;
   logic [2:0]                squash;

   // Stage next-state: hold by default, shift on advance, then flush clears stages 1-2.
   always_comb begin
      for (int unsigned k = 0; k < 4; k++) begin
         reg_d[k]  = reg_q[k];
         wr_d[k]   = wr_q[k];
         val_d[k]  = val_q[k];
         mask_d[k] = mask_q[k];
      end
      // A write with no enabled lanes changes nothing, so it never becomes valid.
      in_valid = result_write_i & (|result_mask_i);
      if (!stall_i) begin
         for (int unsigned k = 1; k < 4; k++) begin
            reg_d[k]  = reg_q[k-1];
            wr_d[k]   = wr_q[k-1];
            val_d[k]  = val_q[k-1];
            mask_d[k] = mask_q[k-1];
         end
         reg_d[0]  = result_register_i;
         wr_d[0]   = in_valid;
         val_d[0]  = result_value_i;
         mask_d[0] = result_mask_i;
      end
      if (flush_i) begin
         reg_d[0]  = '0;
         wr_d[0]   = 1'b0;
         val_d[0]  = '0;
         mask_d[0] = '0;
         wr_d[1]   = 1'b0;
      end
   end

   // Counter delta: entries entering minus entries retiring or squashed.
   // On a flushed advance only old stage 1 is squashed (old stage 2 moves on to
   // stage 3); on a flushed stall both stages 1 and 2 are squashed in place.
   always_comb begin
      enter  = ~stall_i & ~flush_i & in_valid;
      retire = ~stall_i & wr_q[3];
      squash = '0;
      if (flush_i) begin
         if (stall_i) squash = {2'b00, wr_q[0]} + {2'b00, wr_q[1]};
         else         squash = {2'b00, wr_q[0]};
      end
      count_d = count_q + {2'b00, enter} - {2'b00, retire} - squash;
   end

   // Stage and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned k = 0; k < 4; k++) begin
            reg_q[k]  <= '0;
            wr_q[k]   <= 1'b0;
            val_q[k]  <= '0;
            mask_q[k] <= '0;
         end
         count_q <= '0;
      end else begin
         for (int unsigned k = 0; k < 4; k++) begin
            reg_q[k]  <= reg_d[k];
            wr_q[k]   <= wr_d[k];
            val_q[k]  <= val_d[k];
            mask_q[k] <= mask_d[k];
         end
         count_q <= count_d;
      end
   end

   assign bypass1_register_o = reg_q[0];
   assign bypass1_write_o    = wr_q[0];
   assign bypass1_value_o    = val_q[0];
   assign bypass1_mask_o     = mask_q[0];
   assign bypass2_register_o = reg_q[1];
   assign bypass2_write_o    = wr_q[1];
   assign bypass2_value_o    = val_q[1];
   assign bypass2_mask_o     = mask_q[1];
   assign bypass3_register_o = reg_q[2];
   assign bypass3_write_o    = wr_q[2];
   assign bypass3_value_o    = val_q[2];
   assign bypass3_mask_o     = mask_q[2];
   assign bypass4_register_o = reg_q[3];
   assign bypass4_write_o    = wr_q[3];
   assign bypass4_value_o    = val_q[3];
   assign bypass4_mask_o     = mask_q[3];

   // Commit only while advancing; gating with reset keeps in-flight entries from committing.
   assign rf_write_o      = wr_q[3] & ~stall_i & ~reset;
   assign rf_register_o   = reg_q[3];
   assign rf_value_o      = val_q[3];
   assign rf_mask_o       = mask_q[3];
   assign pending_count_o = count_q;

endmodule

// File: tb/tb_vector_writeback_pipeline.sv
// Directed bench for vector_writeback_pipeline: a table of per-cycle vectors
// for plain streaming, then hand sequences for stall, flush and reset.

`ifndef REG_IDX_WIDTH
`define REG_IDX_WIDTH 5
`endif
`ifndef VECTOR_LANES
`define VECTOR_LANES 16
`endif
`ifndef VECTOR_BITS
`define VECTOR_BITS (`VECTOR_LANES*32)
`endif

module tb_vector_writeback_pipeline;

   logic                       clk = 1'b0;
   logic                       reset;
   logic                       stall_i;
   logic                       flush_i;
   logic                       result_write_i;
   logic [`REG_IDX_WIDTH-1:0]  result_register_i;
   logic [`VECTOR_BITS-1:0]    result_value_i;
   logic [`VECTOR_LANES-1:0]   result_mask_i;
   logic [`REG_IDX_WIDTH-1:0]  b1_reg, b2_reg, b3_reg, b4_reg;
   logic                       b1_w, b2_w, b3_w, b4_w;
   logic [`VECTOR_BITS-1:0]    b1_val, b2_val, b3_val, b4_val;
   logic [`VECTOR_LANES-1:0]   b1_mask, b2_mask, b3_mask, b4_mask;
   logic                       rf_write;
   logic [`REG_IDX_WIDTH-1:0]  rf_register;
   logic [`VECTOR_BITS-1:0]    rf_value;
   logic [`VECTOR_LANES-1:0]   rf_mask;
   logic [2:0]                 pending;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   vector_writeback_pipeline dut (
      .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
      .result_write_i(result_write_i), .result_register_i(result_register_i),
      .result_value_i(result_value_i), .result_mask_i(result_mask_i),
      .bypass1_register_o(b1_reg), .bypass1_write_o(b1_w), .bypass1_value_o(b1_val), .bypass1_mask_o(b1_mask),
      .bypass2_register_o(b2_reg), .bypass2_write_o(b2_w), .bypass2_value_o(b2_val), .bypass2_mask_o(b2_mask),
      .bypass3_register_o(b3_reg), .bypass3_write_o(b3_w), .bypass3_value_o(b3_val), .bypass3_mask_o(b3_mask),
      .bypass4_register_o(b4_reg), .bypass4_write_o(b4_w), .bypass4_value_o(b4_val), .bypass4_mask_o(b4_mask),
      .rf_write_o(rf_write), .rf_register_o(rf_register), .rf_value_o(rf_value), .rf_mask_o(rf_mask),
      .pending_count_o(pending)
   );

   typedef struct {
      logic        w;
      logic [4:0]  rg;
      logic [15:0] mk;
      int unsigned base;
      logic [2:0]  e_pend;
      logic [3:0]  e_bw;
      logic        e_rfw;
      logic [4:0]  e_rfreg;
      logic [15:0] e_rfmask;
      int unsigned e_rfbase;
      logic [4:0]  e_b1reg;
      logic [15:0] e_b1mask;
      logic [15:0] e_b2mask;
   } vec_t;

   vec_t tbl [16];

   function automatic logic [`VECTOR_BITS-1:0] mkval(input int unsigned base);
      logic [`VECTOR_BITS-1:0] v;
      v = '0;
      for (int n = 0; n < `VECTOR_LANES; n++) v[n*32 +: 32] = base + n;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [`VECTOR_BITS-1:0] act, input logic [`VECTOR_BITS-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Present inputs just after a rising edge, then wait to mid-cycle for sampling.
   task automatic drive(input logic st, input logic fl, input logic w, input logic [4:0] rg,
                        input logic [15:0] mk, input int unsigned base);
      stall_i           = st;
      flush_i           = fl;
      result_write_i    = w;
      result_register_i = rg;
      result_mask_i     = mk;
      result_value_i    = (w || mk != 16'h0) ? mkval(base) : '0;
      @(negedge clk);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 5'd0, 16'h0, 0);
   endtask

   // Load n valid entries regs 1..n, full mask, bases 10,20,...
   task automatic fill(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, 1'b0, 1'b1, 5'(i + 1), 16'hFFFF, 10 * (i + 1));
         tick();
      end
   endtask

   function automatic logic [3:0] bw();
      return {b4_w, b3_w, b2_w, b1_w};
   endfunction

   initial begin
      //             w  rg  mk         base pend bw       rfw rfreg rfmask    rfbase b1reg b1mask    b2mask
      tbl[0]  = '{1'b1, 5, 16'hFFFF,   0,   0, 4'b0000, 1'b0, 0, 16'h0000,   0,   0, 16'h0000, 16'h0000};
      tbl[1]  = '{1'b0, 0, 16'h0000,   0,   1, 4'b0001, 1'b0, 0, 16'h0000,   0,   5, 16'hFFFF, 16'h0000};
      tbl[2]  = '{1'b0, 0, 16'h0000,   0,   1, 4'b0010, 1'b0, 0, 16'h0000,   0,   0, 16'h0000, 16'hFFFF};
      tbl[3]  = '{1'b0, 0, 16'h0000,   0,   1, 4'b0100, 1'b0, 0, 16'h0000,   0,   0, 16'h0000, 16'h0000};
      tbl[4]  = '{1'b0, 0, 16'h0000,   0,   1, 4'b1000, 1'b1, 5, 16'hFFFF,   0,   0, 16'h0000, 16'h0000};
      tbl[5]  = '{1'b1, 3, 16'h00FF, 100,   0, 4'b0000, 1'b0, 0, 16'h0000,   0,   0, 16'h0000, 16'h0000};
      tbl[6]  = '{1'b1, 3, 16'hFF00, 200,   1, 4'b0001, 1'b0, 0, 16'h0000,   0,   3, 16'h00FF, 16'h0000};
      tbl[7]  = '{1'b0, 0, 16'h0000,   0,   2, 4'b0011, 1'b0, 0, 16'h0000,   0,   3, 16'hFF00, 16'h00FF};
      tbl[8]  = '{1'b0, 0, 16'h0000,   0,   2, 4'b0110, 1'b0, 0, 16'h0000,   0,   0, 16'h0000, 16'hFF00};
      tbl[9]  = '{1'b0, 0, 16'h0000,   0,   2, 4'b1100, 1'b1, 3, 16'h00FF, 100,   0, 16'h0000, 16'h0000};
      tbl[10] = '{1'b0, 0, 16'h0000,   0,   1, 4'b1000, 1'b1, 3, 16'hFF00, 200,   0, 16'h0000, 16'h0000};
      tbl[11] = '{1'b1, 7, 16'h0000, 300,   0, 4'b0000, 1'b0, 0, 16'h0000,   0,   0, 16'h0000, 16'h0000};
      tbl[12] = '{1'b0, 0, 16'h0000,   0,   0, 4'b0000, 1'b0, 0, 16'h0000,   0,   7, 16'h0000, 16'h0000};
      tbl[13] = '{1'b0, 0, 16'h0000,   0,   0, 4'b0000, 1'b0, 0, 16'h0000,   0,   0, 16'h0000, 16'h0000};
      tbl[14] = '{1'b0, 0, 16'h0000,   0,   0, 4'b0000, 1'b0, 0, 16'h0000,   0,   0, 16'h0000, 16'h0000};
      tbl[15] = '{1'b0, 0, 16'h0000,   0,   0, 4'b0000, 1'b0, 0, 16'h0000,   0,   0, 16'h0000, 16'h0000};

      // Reset state, with stall and flush asserted to show reset wins.
      reset = 1'b1;
      drive(1'b1, 1'b1, 1'b1, 5'd9, 16'hFFFF, 1);
      tick();
      drive(1'b1, 1'b1, 1'b1, 5'd9, 16'hFFFF, 1);
      chk("rst_pend", pending, 0);
      chk("rst_bw", bw(), 0);
      chk("rst_rfw", rf_write, 0);
      chk("rst_b1reg", b1_reg, 0);
      chk("rst_b1val", b1_val, 0);
      tick();
      reset = 1'b0;

      // Streaming vectors: single write, back-to-back partial masks, zero mask.
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 1'b0, tbl[i].w, tbl[i].rg, tbl[i].mk, tbl[i].base);
         chk($sformatf("r%0d_pend", i), pending, tbl[i].e_pend);
         chk($sformatf("r%0d_bw", i), bw(), tbl[i].e_bw);
         chk($sformatf("r%0d_rfw", i), rf_write, tbl[i].e_rfw);
         chk($sformatf("r%0d_b1reg", i), b1_reg, tbl[i].e_b1reg);
         chk($sformatf("r%0d_b1mask", i), b1_mask, tbl[i].e_b1mask);
         chk($sformatf("r%0d_b2mask", i), b2_mask, tbl[i].e_b2mask);
         if (tbl[i].e_rfw) begin
            chk($sformatf("r%0d_rfreg", i), rf_register, tbl[i].e_rfreg);
            chk($sformatf("r%0d_rfmask", i), rf_mask, tbl[i].e_rfmask);
            chk($sformatf("r%0d_rfval", i), rf_value, mkval(tbl[i].e_rfbase));
         end
         tick();
      end

      // Stall with a valid entry in stage 4 for three cycles.
      drive(1'b0, 1'b0, 1'b1, 5'd9, 16'hFFFF, 400);
      tick();
      for (int i = 0; i < 3; i++) begin idle(); tick(); end
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 1'b0, 5'd0, 16'h0, 0);
         chk($sformatf("stall%0d_rfw", i), rf_write, 0);
         chk($sformatf("stall%0d_bw", i), bw(), 4'b1000);
         chk($sformatf("stall%0d_b4reg", i), b4_reg, 9);
         chk($sformatf("stall%0d_b4val", i), b4_val, mkval(400));
         chk($sformatf("stall%0d_pend", i), pending, 1);
         tick();
      end
      idle();
      chk("stall_rel_rfw", rf_write, 1);
      chk("stall_rel_rfval", rf_value, mkval(400));
      tick();
      idle();
      chk("stall_after_rfw", rf_write, 0);
      chk("stall_after_pend", pending, 0);
      tick();

      // Flush while advancing with four valid entries and a valid incoming result.
      fill(4);
      drive(1'b0, 1'b1, 1'b1, 5'd6, 16'hFFFF, 50);
      chk("fl_rfw", rf_write, 1);
      chk("fl_rfreg", rf_register, 1);
      chk("fl_pend", pending, 4);
      chk("fl_bw", bw(), 4'b1111);
      tick();
      idle();
      chk("fl1_bw", bw(), 4'b1100);
      chk("fl1_b3reg", b3_reg, 3);
      chk("fl1_b4reg", b4_reg, 2);
      chk("fl1_pend", pending, 2);
      chk("fl1_rfw", rf_write, 1);
      tick();
      idle();
      chk("fl2_pend", pending, 1);
      chk("fl2_rfreg", rf_register, 3);
      chk("fl2_rfw", rf_write, 1);
      tick();
      idle();
      chk("fl3_pend", pending, 0);
      chk("fl3_rfw", rf_write, 0);
      tick();

      // Flush during a stall: stages 1-2 squashed in place, 3-4 hold, no commit.
      fill(4);
      drive(1'b1, 1'b1, 1'b1, 5'd6, 16'hFFFF, 50);
      chk("fs_rfw", rf_write, 0);
      chk("fs_pend", pending, 4);
      tick();
      idle();
      chk("fs1_bw", bw(), 4'b1100);
      chk("fs1_b3reg", b3_reg, 2);
      chk("fs1_pend", pending, 2);
      chk("fs1_rfw", rf_write, 1);
      chk("fs1_rfreg", rf_register, 1);
      tick();
      idle();
      chk("fs2_pend", pending, 1);
      chk("fs2_rfreg", rf_register, 2);
      tick();
      idle();
      chk("fs3_pend", pending, 0);
      chk("fs3_rfw", rf_write, 0);
      tick();

      // Reset with three entries in flight, stall and flush also high.
      fill(3);
      reset = 1'b1;
      drive(1'b1, 1'b1, 1'b1, 5'd6, 16'hFFFF, 50);
      chk("r3_rfw_during", rf_write, 0);
      tick();
      reset = 1'b0;
      idle();
      chk("r3_bw", bw(), 0);
      chk("r3_pend", pending, 0);
      tick();
      for (int i = 0; i < 4; i++) begin
         idle();
         chk($sformatf("r3_drain%0d_rfw", i), rf_write, 0);
         chk($sformatf("r3_drain%0d_pend", i), pending, 0);
         tick();
      end

      // Reset while stage 4 holds a valid entry: no commit during or after.
      fill(4);
      reset = 1'b1;
      idle();
      chk("r4_rfw_during", rf_write, 0);
      tick();
      reset = 1'b0;
      idle();
      chk("r4_bw", bw(), 0);
      chk("r4_pend", pending, 0);
      chk("r4_rfw", rf_write, 0);
      tick();
      for (int i = 0; i < 3; i++) begin
         idle();
         chk($sformatf("r4_drain%0d_rfw", i), rf_write, 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
